// File: rtl/gyro_window_avg.sv
// gyro_window_avg: multi-channel windowed gyro averager, fixed-point out.
// Define GYRO_BIAS_CAL_EN to build the zero-rate bias calibration FSM.
module gyro_window_avg #(
  parameter int NUM_CH      = 3,
  parameter int IN_W        = 16,
  parameter int WINDOW      = 10000,
  parameter int FRAC_W      = 16,
  parameter int OUT_W       = 32,
  parameter int RECIP_SHIFT = 24
) (
  input  logic                     clk_100mhz,
  input  logic                     rst_in,
  input  logic                     sample_valid_in,
  input  logic [NUM_CH*IN_W-1:0]   data_in,
  input  logic                     cal_start_in,
  output logic [NUM_CH*OUT_W-1:0]  avg_out,
  output logic                     avg_valid_out,
  output logic                     cal_busy_out,
  output logic                     cal_done_out
);
  localparam int CNT_W  = $clog2(WINDOW + 1);
  localparam int ACC_W  = IN_W + 1 + CNT_W;
  localparam int SH     = RECIP_SHIFT - FRAC_W;
  localparam int RC_W   = RECIP_SHIFT + 2;
  localparam int PROD_W = ACC_W + RC_W;
  localparam longint RECIP =
    ((longint'(1) <<< RECIP_SHIFT) + longint'(WINDOW / 2))
    / longint'(WINDOW);
  localparam logic signed [RC_W-1:0] RECIP_C = RC_W'(RECIP);
  localparam logic signed [PROD_W-1:0] MAXV =
    {{(PROD_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [PROD_W-1:0] MINV =
    {{(PROD_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  logic signed [ACC_W-1:0]  acc     [NUM_CH];
  logic signed [ACC_W-1:0]  acc_nxt [NUM_CH];
  logic signed [ACC_W-1:0]  snap    [NUM_CH];
  logic signed [PROD_W-1:0] prod    [NUM_CH];
  logic signed [PROD_W-1:0] sh      [NUM_CH];
  logic        [OUT_W-1:0]  sat     [NUM_CH];
  logic [CNT_W-1:0] cnt;
  logic close, in_cal, start, cal_pend;
  logic s1_vld, s1_cal, s2_vld, s2_cal;

`ifdef GYRO_BIAS_CAL_EN
  typedef enum logic {RUN, CAL} state_t;
  state_t state, state_nxt;
  logic signed [IN_W-1:0] bias [NUM_CH];

  assign in_cal       = (state == CAL);
  assign start        = (state == RUN) && cal_start_in;
  assign cal_busy_out = in_cal;

  always_comb begin
    state_nxt = state;
    unique case (state)
      RUN:     if (cal_start_in) state_nxt = CAL;
      CAL:     if (s2_vld && s2_cal) state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk_100mhz) begin
    if (rst_in) begin
      state    <= RUN;
      cal_pend <= 1'b0;
      cal_done_out <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) bias[c] <= '0;
    end else begin
      state <= state_nxt;
      cal_done_out <= s2_vld && s2_cal;
      if (close && in_cal) cal_pend <= 1'b1;
      if (s2_vld && s2_cal) begin
        cal_pend <= 1'b0;
        for (int c = 0; c < NUM_CH; c++)
          bias[c] <= IN_W'(prod[c] >>> RECIP_SHIFT);
      end
    end
  end
`else
  assign in_cal       = 1'b0;
  assign start        = cal_start_in & 1'b0;
  assign cal_pend     = 1'b0;
  assign cal_busy_out = 1'b0;
  assign cal_done_out = 1'b0;
`endif

  assign close = sample_valid_in && (cnt == CNT_W'(WINDOW - 1));

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
`ifdef GYRO_BIAS_CAL_EN
      acc_nxt[c] = acc[c]
        + ACC_W'($signed(data_in[c*IN_W +: IN_W]))
        - ACC_W'(bias[c]);
`else
      acc_nxt[c] = acc[c]
        + ACC_W'($signed(data_in[c*IN_W +: IN_W]));
`endif
      sh[c] = prod[c] >>> SH;
      if (sh[c] > MAXV)      sat[c] = MAXV[OUT_W-1:0];
      else if (sh[c] < MINV) sat[c] = MINV[OUT_W-1:0];
      else                   sat[c] = sh[c][OUT_W-1:0];
    end
  end

  // A calibration start discards the partial window but a window
  // closing in the same cycle still reaches the pipeline.
  always_ff @(posedge clk_100mhz) begin
    if (rst_in || start) begin
      cnt <= '0;
      for (int c = 0; c < NUM_CH; c++) acc[c] <= '0;
    end else if (sample_valid_in) begin
      if (close) begin
        cnt <= '0;
        for (int c = 0; c < NUM_CH; c++) acc[c] <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
        for (int c = 0; c < NUM_CH; c++) acc[c] <= acc_nxt[c];
      end
    end
  end

  always_ff @(posedge clk_100mhz) begin
    if (rst_in) begin
      s1_vld <= 1'b0;
      s1_cal <= 1'b0;
      s2_vld <= 1'b0;
      s2_cal <= 1'b0;
      avg_valid_out <= 1'b0;
      avg_out <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        snap[c] <= '0;
        prod[c] <= '0;
      end
    end else begin
      s1_vld <= close && !(in_cal && cal_pend);
      s1_cal <= in_cal;
      s2_vld <= s1_vld;
      s2_cal <= s1_cal;
      avg_valid_out <= s2_vld && !s2_cal;
      for (int c = 0; c < NUM_CH; c++) begin
        if (close)  snap[c] <= acc_nxt[c];
        if (s1_vld) prod[c] <= PROD_W'(snap[c]) * PROD_W'(RECIP_C);
        if (s2_vld && !s2_cal) avg_out[c*OUT_W +: OUT_W] <= sat[c];
      end
    end
  end

endmodule
